// File: rtl/hit_feeder.sv
// rtl/hit_feeder.sv - Hit FIFO feeding the HXMPP write port, with per-event hit counting
module hit_feeder #(
    parameter int ROWINDEXBITS_HCM = 10,
    parameter int HITINFOBITS      = 8,
    parameter int DEPTH            = 16,
    parameter int DEPTHBITS        = 4,
    parameter int HITCOUNTBITS     = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ROWINDEXBITS_HCM-1:0] in_SSID,
    input  logic [HITINFOBITS-1:0]      in_hitInfo,
    input  logic                        in_eventEnd,
    input  logic                        writeReady,
    input  logic                        hxmppBusy,
    output logic                        write,
    output logic [ROWINDEXBITS_HCM-1:0] writeSSID,
    output logic [HITINFOBITS-1:0]      writeHitInfo,
    output logic [DEPTHBITS:0]          fifoCount,
    output logic                        eventDone,
    output logic [HITCOUNTBITS-1:0]     nHitsEvent
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int                      ENTRYW     = ROWINDEXBITS_HCM + HITINFOBITS;
    localparam logic [DEPTHBITS:0]      FULL_COUNT = (DEPTHBITS + 1)'(DEPTH);
    localparam logic [HITCOUNTBITS-1:0] HIT_MAX    = '1;

    state_t                      state_q, state_d;
    logic [DEPTHBITS-1:0]        wr_ptr_q, wr_ptr_d;
    logic [DEPTHBITS-1:0]        rd_ptr_q, rd_ptr_d;
    logic [DEPTHBITS:0]          count_q, count_d;
    logic [HITCOUNTBITS-1:0]     hits_q, hits_d;
    logic [HITCOUNTBITS-1:0]     nhits_q, nhits_d;
    logic                        write_q;
    logic [ROWINDEXBITS_HCM-1:0] wssid_q;
    logic [HITINFOBITS-1:0]      winfo_q;
    logic [ENTRYW-1:0]           mem_q [DEPTH];

    logic accepting;
    logic push;
    logic end_acc;
    logic pop;

    always_comb begin
        accepting = (state_q == ST_IDLE || state_q == ST_STREAM) && (count_q != FULL_COUNT);
        in_ready  = accepting && !reset;
        push      = in_valid && in_ready;
        end_acc   = in_eventEnd && in_ready;
        pop       = (count_q != '0) && writeReady;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (end_acc) begin
                    state_d = ST_DRAIN;
                end else if (push) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (end_acc) begin
                    state_d = ST_DRAIN;
                end
            end
            // Wait until the last strobe has left and HXMPP has finished with it.
            ST_DRAIN: begin
                if (count_q == '0 && !write_q && !hxmppBusy) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hits_d  = hits_q;
        nhits_d = nhits_q;
        // Leaving IDLE starts a new event, including an empty one.
        if (state_q == ST_IDLE && state_d != ST_IDLE) begin
            hits_d = '0;
        end else if (pop && hits_q != HIT_MAX) begin
            hits_d = hits_q + 1'b1;
        end
        if (state_q == ST_DRAIN && state_d == ST_DONE) begin
            nhits_d = hits_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_SSID, in_hitInfo};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hits_q   <= '0;
            nhits_q  <= '0;
            write_q  <= 1'b0;
            wssid_q  <= '0;
            winfo_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hits_q   <= hits_d;
            nhits_q  <= nhits_d;
            write_q  <= pop;
            if (pop) begin
                {wssid_q, winfo_q} <= mem_q[rd_ptr_q];
            end
        end
    end

    always_comb begin
        write        = write_q;
        writeSSID    = wssid_q;
        writeHitInfo = winfo_q;
        fifoCount    = count_q;
        eventDone    = (state_q == ST_DONE);
        nHitsEvent   = nhits_q;
    end

endmodule
